// File: rtl/muldiv_pkg.sv
// Shared arithmetic-datapath definitions for the sequential multiplier and divider.
// FSM encoding, default widths and the quotient pattern reported on overflow.
`default_nettype none

package muldiv_pkg;

  localparam int DEF_MBITS     = 12;
  localparam int DEF_NBITS     = 8;
  localparam int DEF_COUNTBITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Wide all-ones source; each user slices it down to its own quotient width.
  localparam logic [63:0] OVF_QUOT_ALL = {64{1'b1}};

endpackage : muldiv_pkg

`default_nettype wire

// File: rtl/seq_div_if.sv
// Start/busy handshake bundle for seq_div: operands in, registered result and status out.
`default_nettype none

interface seq_div_if
  import muldiv_pkg::*;
#(
  parameter int MBITS = DEF_MBITS,
  parameter int NBITS = DEF_NBITS
);

  logic                   start;
  logic [MBITS+NBITS-1:0] xDvd;
  logic [MBITS-1:0]       xDvs;
  logic [NBITS-1:0]       xQuot;
  logic [MBITS-1:0]       xRem;
  logic                   busy;
  logic                   ovf;

  modport master (
    output start, xDvd, xDvs,
    input  xQuot, xRem, busy, ovf
  );

  modport slave (
    input  start, xDvd, xDvs,
    output xQuot, xRem, busy, ovf
  );

endinterface : seq_div_if

`default_nettype wire

// File: rtl/div_step.sv
// One restoring-division step: trial subtract via the alu form A + ~B + 1, keep or restore.
`default_nettype none

module div_step #(
  parameter int W = 13
) (
  input  logic [W-1:0] rShift_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rNext_o,
  output logic         qBit_o
);

  logic [W:0] sum;

  // Carry out of A + ~B + 1 is set exactly when A >= B, i.e. no borrow.
  assign sum     = {1'b0, rShift_i} + {1'b0, ~dvs_i} + (W+1)'(1);
  assign qBit_o  = sum[W];
  assign rNext_o = sum[W] ? sum[W-1:0] : rShift_i;

endmodule : div_step

`default_nettype wire

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock, start/busy handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating quotient).
`default_nettype none

module seq_div
  import muldiv_pkg::*;
#(
  parameter int MBITS     = DEF_MBITS,
  parameter int NBITS     = DEF_NBITS,
  parameter int COUNTBITS = DEF_COUNTBITS
) (
  input  wire        wClk,
  input  wire        wRst_n,
  seq_div_if.slave   bus
);

  localparam int DW = MBITS + NBITS;
  localparam logic [NBITS-1:0] OVF_QUOT = OVF_QUOT_ALL[NBITS-1:0];

  md_state_e            state_q, state_d;
  logic [DW-1:0]        dvd_q, dvd_d;
  logic [MBITS-1:0]     dvs_q, dvs_d;
  logic [MBITS:0]       r_q, r_d;
  logic [NBITS-1:0]     q_q, q_d;
  logic [COUNTBITS-1:0] cnt_q, cnt_d;
  logic                 ovfPend_q, ovfPend_d;
  logic [NBITS-1:0]     quot_q, quot_d;
  logic [MBITS-1:0]     rem_q, rem_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;

  logic [DW-1:0]        dvdMag;
  logic [MBITS-1:0]     dvsMag;
  logic                 ovfCond;
  logic [NBITS-1:0]     quotFix;
  logic [MBITS-1:0]     remFix;
  logic                 rangeOvf;
  logic [MBITS:0]       shiftR;
  logic [MBITS:0]       stepR;
  logic                 stepQ;

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [NBITS-1:0] Q_HALF = {1'b1, {(NBITS-1){1'b0}}};

  logic negQ_q, negQ_d;
  logic negR_q, negR_d;

  assign dvdMag = dvd_q[DW-1]    ? (~dvd_q + DW'(1))    : dvd_q;
  assign dvsMag = dvs_q[MBITS-1] ? (~dvs_q + MBITS'(1)) : dvs_q;

  assign quotFix  = negQ_q ? (~q_q + NBITS'(1)) : q_q;
  assign remFix   = negR_q ? (~r_q[MBITS-1:0] + MBITS'(1)) : r_q[MBITS-1:0];
  // A negative quotient may reach -2**(NBITS-1); a positive one stops one short.
  assign rangeOvf = negQ_q ? (q_q > Q_HALF) : (q_q >= Q_HALF);
`else
  assign dvdMag   = dvd_q;
  assign dvsMag   = dvs_q;
  assign quotFix  = q_q;
  assign remFix   = r_q[MBITS-1:0];
  assign rangeOvf = 1'b0;
`endif

  assign ovfCond = (dvsMag == '0) || (dvdMag[DW-1:NBITS] >= dvsMag);

  assign shiftR = {r_q[MBITS-1:0], q_q[NBITS-1]};

  div_step #(
    .W (MBITS + 1)
  ) u_step (
    .rShift_i (shiftR),
    .dvs_i    ({1'b0, dvs_q}),
    .rNext_o  (stepR),
    .qBit_o   (stepQ)
  );

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    r_d       = r_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    ovfPend_d = ovfPend_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
`ifdef SEQ_DIV_SIGNED_EN
    negQ_d    = negQ_q;
    negR_d    = negR_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.xDvd;
          dvs_d   = bus.xDvs;
          busy_d  = 1'b1;
          state_d = ST_PREP;
        end
      end

      ST_PREP: begin
        ovfPend_d = ovfCond;
        dvs_d     = dvsMag;
        r_d       = {1'b0, dvdMag[DW-1:NBITS]};
        q_d       = dvdMag[NBITS-1:0];
        cnt_d     = '0;
`ifdef SEQ_DIV_SIGNED_EN
        negQ_d    = dvd_q[DW-1] ^ dvs_q[MBITS-1];
        negR_d    = dvd_q[DW-1];
`endif
        state_d   = ovfCond ? ST_FIX : ST_ITER;
      end

      ST_ITER: begin
        r_d   = stepR;
        q_d   = {q_q[NBITS-2:0], stepQ};
        cnt_d = cnt_q + COUNTBITS'(1);
        if (cnt_q == COUNTBITS'(NBITS - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        // r_q[MBITS] stays clear for any in-range divide; treat it as a bad result if not.
        if (ovfPend_q || rangeOvf || r_q[MBITS]) begin
          quot_d = OVF_QUOT;
          rem_d  = '0;
          ovf_d  = 1'b1;
        end else begin
          quot_d = quotFix;
          rem_d  = remFix;
          ovf_d  = 1'b0;
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wClk or negedge wRst_n) begin
    if (!wRst_n) begin
      state_q   <= ST_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      ovfPend_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      r_q       <= r_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      ovfPend_q <= ovfPend_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
`ifdef SEQ_DIV_SIGNED_EN
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
`endif
    end
  end

  assign bus.xQuot = quot_q;
  assign bus.xRem  = rem_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;

endmodule : seq_div

`default_nettype wire

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (MBITS=12, NBITS=8): vector table plus handshake/reset sequences.
`default_nettype none

module tb_seq_div;

  localparam int MB = 12;
  localparam int NB = 8;

  typedef struct {
    logic [MB+NB-1:0] dvd;
    logic [MB-1:0]    dvs;
    logic [NB-1:0]    quot;
    logic [MB-1:0]    rem;
    logic             ovf;
    int               lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  seq_div_if #(.MBITS(MB), .NBITS(NB)) bus ();

  seq_div #(
    .MBITS     (MB),
    .NBITS     (NB),
    .COUNTBITS (4)
  ) dut (
    .wClk   (clk),
    .wRst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for busy to fall; lat counts edges after acceptance.
  task automatic run_op(input logic [MB+NB-1:0] dvd, input logic [MB-1:0] dvs, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.xDvd  = dvd;
    bus.xDvs  = dvs;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.busy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) check("busy_timeout", 32'd1, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    n_checks  = 0;
    n_errors  = 0;
    bus.start = 1'b0;
    bus.xDvd  = '0;
    bus.xDvs  = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_quot", 32'(bus.xQuot), 32'd0);
    check("reset_rem",  32'(bus.xRem),  32'd0);
    check("reset_ovf",  32'(bus.ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back('{20'hFFF9C, 12'd7,   8'hF2, 12'hFFE, 1'b0, 10}); // -100 / 7
    vecs.push_back('{20'hFFF9C, 12'hFF9, 8'h0E, 12'hFFE, 1'b0, 10}); // -100 / -7
    vecs.push_back('{20'd100,   12'hFF9, 8'hF2, 12'd2,   1'b0, 10}); // 100 / -7
    vecs.push_back('{20'hFFC00, 12'd8,   8'h80, 12'd0,   1'b0, 10}); // -1024/8 = -128
    vecs.push_back('{20'd1024,  12'd8,   8'hFF, 12'd0,   1'b1, 10}); // +128 out of range
    vecs.push_back('{20'd5,     12'd0,   8'hFF, 12'd0,   1'b1, 2});
`else
    vecs.push_back('{20'd1000,  12'd7,    8'd142, 12'd6,    1'b0, 10});
    vecs.push_back('{20'd500,   12'd0,    8'hFF,  12'd0,    1'b1, 2});
    vecs.push_back('{20'h0FFFF, 12'd16,   8'hFF,  12'd0,    1'b1, 2});
    vecs.push_back('{20'hFFEFF, 12'd4095, 8'd255, 12'd4094, 1'b0, 10});
    vecs.push_back('{20'h12345, 12'h123,  8'hFF,  12'd0,    1'b1, 2});  // high part == divisor
    vecs.push_back('{20'h12244, 12'h123,  8'd255, 12'd103,  1'b0, 10});
    vecs.push_back('{20'd0,     12'd5,    8'd0,   12'd0,    1'b0, 10});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat);
      check($sformatf("v%0d_quot", i), 32'(bus.xQuot), 32'(vecs[i].quot));
      check($sformatf("v%0d_rem", i),  32'(bus.xRem),  32'(vecs[i].rem));
      check($sformatf("v%0d_ovf", i),  32'(bus.ovf),   32'(vecs[i].ovf));
      check($sformatf("v%0d_lat", i),  32'(lat),       32'(vecs[i].lat));
    end

    // start pulsed while busy must be ignored: 100/7 = 14 r 2 in both builds.
    @(negedge clk);
    bus.start = 1'b1; bus.xDvd = 20'd100; bus.xDvs = 12'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.xDvd = 20'd500; bus.xDvs = 12'd3;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignored_start_quot", 32'(bus.xQuot), 32'd14);
    check("ignored_start_rem",  32'(bus.xRem),  32'd2);
    check("ignored_start_ovf",  32'(bus.ovf),   32'd0);
    repeat (3) @(negedge clk);
    check("ignored_start_idle", 32'(bus.busy),  32'd0);

    // Reset during cycle 4 of a new op; outputs held until then, cleared at once.
    @(negedge clk);
    bus.start = 1'b1; bus.xDvd = 20'd3000; bus.xDvs = 12'd13;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_during_op_quot", 32'(bus.xQuot), 32'd14);
    check("hold_during_op_busy", 32'(bus.busy),  32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy),  32'd0);
    check("midreset_quot", 32'(bus.xQuot), 32'd0);
    check("midreset_rem",  32'(bus.xRem),  32'd0);
    check("midreset_ovf",  32'(bus.ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(20'd100, 12'd7, lat);
    check("post_reset_quot", 32'(bus.xQuot), 32'd14);
    check("post_reset_rem",  32'(bus.xRem),  32'd2);
    check("post_reset_lat",  32'(lat),       32'd10);

    // start held high across completion: next op accepted on the first IDLE edge.
    @(negedge clk);
    bus.start = 1'b1; bus.xDvd = 20'd100; bus.xDvs = 12'd7;
    @(posedge clk);
    #1;
    lat = 0;
    while (bus.busy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held_start_lat",  32'(lat),       32'd10);
    check("held_start_quot", 32'(bus.xQuot), 32'd14);
    @(posedge clk);
    #1;
    check("held_start_reaccept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    lat = 0;
    while (bus.busy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held_start_second_lat", 32'(lat), 32'd10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_seq_div

`default_nettype wire
